// File: rtl/hb_task_pkg.sv
// rtl/hb_task_pkg.sv - shared types and helpers for the hb task scheduler
package hb_task_pkg;

   localparam int TASK_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      ISSUE = 2'd2
   } sched_state_e;

   // Counter must represent 0..credits inclusive.
   function automatic int credit_w(input int credits);
      return (credits < 1) ? 1 : $clog2(credits + 1);
   endfunction

endpackage

// File: rtl/hb_rr_arbiter.sv
// rtl/hb_rr_arbiter.sv - combinational rotate-priority pick starting at rr_ptr
module hb_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         eligible,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         grant_onehot,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       any_grant
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      any_grant    = 1'b0;
      sum          = '0;
      idx          = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // One extra bit keeps the wrap correct for non-power-of-two NUM_REQ.
         sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
         idx = sum[IDX_W-1:0];
         if (!any_grant && eligible[idx]) begin
            any_grant         = 1'b1;
            grant_idx         = idx;
            grant_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hb_task_scheduler.sv
// rtl/hb_task_scheduler.sv - round-robin, credit-gated task issue onto one hb distributor
module hb_task_scheduler
   import hb_task_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TASK_W  = TASK_W_DEF,
   parameter int CREDITS = 1,
   parameter int CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*TASK_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_enable,
   output logic                        dist_valid,
   output logic [TASK_W-1:0]           dist_data,
   input  logic                        credit_return,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy,
   output logic [CNT_W-1:0]            issued_cnt,
   output logic                        err_credit
);
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int CRED_W = credit_w(CREDITS);

   sched_state_e      state_q, state_d;
   logic [CRED_W-1:0] credits_q, credits_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  grant_id_q, grant_id_d;
   logic [TASK_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;
   logic              err_credit_q, err_credit_d;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] arb_onehot;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic               issue;
   logic               can_grant;

   assign eligible  = req_valid & req_enable;
   assign issue     = (state_q == ISSUE);
   assign can_grant = (state_q == IDLE) && (credits_q != '0) && arb_any;

   hb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .eligible     (eligible),
      .rr_ptr       (rr_ptr_q),
      .grant_onehot (arb_onehot),
      .grant_idx    (arb_idx),
      .any_grant    (arb_any)
   );

   always_comb begin
      state_d      = state_q;
      credits_d    = credits_q;
      rr_ptr_d     = rr_ptr_q;
      grant_id_d   = grant_id_q;
      hold_d       = hold_q;
      issued_cnt_d = issued_cnt_q;
      err_credit_d = err_credit_q;
      req_ready    = '0;

      case (state_q)
         IDLE: begin
            if (can_grant) begin
               req_ready  = arb_onehot;
               hold_d     = req_data[int'(arb_idx)*TASK_W +: TASK_W];
               grant_id_d = arb_idx;
               state_d    = SETUP;
            end
         end
         SETUP: state_d = ISSUE;
         ISSUE: begin
            rr_ptr_d     = (grant_id_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_id_q + IDX_W'(1);
            issued_cnt_d = issued_cnt_q + CNT_W'(1);
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A return coinciding with an issue cancels out, so it can never overflow.
      if (issue && !credit_return) begin
         credits_d = credits_q - CRED_W'(1);
      end else if (credit_return && !issue) begin
         if (credits_q == CRED_W'(CREDITS)) err_credit_d = 1'b1;
         else                               credits_d    = credits_q + CRED_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         credits_q    <= CRED_W'(CREDITS);
         rr_ptr_q     <= '0;
         grant_id_q   <= '0;
         hold_q       <= '0;
         issued_cnt_q <= '0;
         err_credit_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         credits_q    <= credits_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_id_q   <= grant_id_d;
         hold_q       <= hold_d;
         issued_cnt_q <= issued_cnt_d;
         err_credit_q <= err_credit_d;
      end
   end

   assign dist_valid = issue;
   assign dist_data  = hold_q;
   assign grant_id   = grant_id_q;
   assign busy       = (state_q != IDLE);
   assign issued_cnt = issued_cnt_q;
   assign err_credit = err_credit_q;

endmodule

// File: tb/tb_hb_task_scheduler.sv
// tb/tb_hb_task_scheduler.sv - directed self-checking bench for hb_task_scheduler
module tb_hb_task_scheduler;
   localparam int NUM_REQ = 4;
   localparam int TASK_W  = 32;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*TASK_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_enable;
   logic                      dist_valid;
   logic [TASK_W-1:0]         dist_data;
   logic                      credit_return;
   logic [1:0]                grant_id;
   logic                      busy;
   logic [15:0]               issued_cnt;
   logic                      err_credit;

   logic [NUM_REQ-1:0]        w_req_ready;
   logic                      w_dist_valid;
   logic [TASK_W-1:0]         w_dist_data;
   logic [1:0]                w_grant_id;
   logic                      w_busy;
   logic [1:0]                w_issued_cnt;
   logic                      w_err_credit;

   int checks = 0;
   int errors = 0;
   int exp_cnt;
   int exp_g [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
   logic [TASK_W-1:0] rr_data [NUM_REQ] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};

   always #5 clk = ~clk;

   hb_task_scheduler #(.NUM_REQ(NUM_REQ), .TASK_W(TASK_W), .CREDITS(1), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .req_enable(req_enable), .dist_valid(dist_valid),
      .dist_data(dist_data), .credit_return(credit_return), .grant_id(grant_id),
      .busy(busy), .issued_cnt(issued_cnt), .err_credit(err_credit)
   );

   // Narrow counter instance: same stimulus, exercises the silent wrap.
   hb_task_scheduler #(.NUM_REQ(NUM_REQ), .TASK_W(TASK_W), .CREDITS(1), .CNT_W(2)) u_dut_w (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(w_req_ready), .req_enable(req_enable), .dist_valid(w_dist_valid),
      .dist_data(w_dist_data), .credit_return(credit_return), .grant_id(w_grant_id),
      .busy(w_busy), .issued_cnt(w_issued_cnt), .err_credit(w_err_credit)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_data = '0; req_enable = '1; credit_return = 1'b0;
      tick(); tick();
      reset = 1'b0; #1;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_dvalid", 64'(dist_valid), 64'h0);
      chk("rst_ddata", 64'(dist_data), 64'h0);
      chk("rst_gid", 64'(grant_id), 64'h0);
      chk("rst_cnt", 64'(issued_cnt), 64'h0);
      chk("rst_err", 64'(err_credit), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);

      // Single request
      req_valid = 4'b0001; req_data[0 +: 32] = 32'hA5A5_0001; #1;
      chk("single_ready", 64'(req_ready), 64'h1);
      tick(); req_valid = '0; #1;
      chk("single_setup_busy", 64'(busy), 64'h1);
      chk("single_setup_ready", 64'(req_ready), 64'h0);
      chk("single_setup_dvalid", 64'(dist_valid), 64'h0);
      chk("single_setup_ddata", 64'(dist_data), 64'hA5A5_0001);
      tick(); #1;
      chk("single_issue_dvalid", 64'(dist_valid), 64'h1);
      chk("single_issue_ddata", 64'(dist_data), 64'hA5A5_0001);
      tick(); #1;
      chk("single_done_dvalid", 64'(dist_valid), 64'h0);
      chk("single_done_cnt", 64'(issued_cnt), 64'h1);
      chk("single_hold_ddata", 64'(dist_data), 64'hA5A5_0001);

      // Credit stall: no credit left
      req_valid = 4'b0001; req_data[0 +: 32] = 32'h1111_0002; #1;
      chk("stall_ready0", 64'(req_ready), 64'h0);
      tick(); tick(); #1;
      chk("stall_ready1", 64'(req_ready), 64'h0);
      chk("stall_busy", 64'(busy), 64'h0);
      credit_return = 1'b1; #1;
      chk("stall_ret_ready", 64'(req_ready), 64'h0);
      tick(); credit_return = 1'b0; #1;
      chk("stall_grant", 64'(req_ready), 64'h1);
      tick(); req_valid = '0; #1;
      chk("stall_setup_dvalid", 64'(dist_valid), 64'h0);
      tick(); #1;
      chk("stall_issue_dvalid", 64'(dist_valid), 64'h1);
      chk("stall_issue_ddata", 64'(dist_data), 64'h1111_0002);
      tick(); #1;
      chk("stall_cnt", 64'(issued_cnt), 64'h2);

      // Reset while in SETUP
      credit_return = 1'b1; tick(); credit_return = 1'b0;
      req_valid = 4'b0100; req_data[64 +: 32] = 32'h2222_0003; #1;
      chk("rsetup_ready", 64'(req_ready), 64'h4);
      tick(); req_valid = '0; #1;
      chk("rsetup_gid", 64'(grant_id), 64'h2);
      chk("rsetup_busy", 64'(busy), 64'h1);
      reset = 1'b1; tick(); reset = 1'b0; #1;
      chk("rsetup_dvalid", 64'(dist_valid), 64'h0);
      chk("rsetup_ddata", 64'(dist_data), 64'h0);
      chk("rsetup_gid0", 64'(grant_id), 64'h0);
      chk("rsetup_cnt", 64'(issued_cnt), 64'h0);
      chk("rsetup_busy0", 64'(busy), 64'h0);
      tick(); #1;
      chk("rsetup_no_issue", 64'(dist_valid), 64'h0);

      // Round robin, then enable mask 1010; credit returned in every ISSUE cycle
      exp_cnt = 0;
      req_valid = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) req_data[i*TASK_W +: TASK_W] = rr_data[i];
      for (int k = 0; k < 9; k++) begin
         if (k == 5) req_enable = 4'b1010;
         #1;
         chk("rr_ready", 64'(req_ready), 64'(4'b0001 << exp_g[k]));
         tick();
         if (k == 8) req_enable = 4'b0000;
         #1;
         chk("rr_gid", 64'(grant_id), 64'(exp_g[k]));
         chk("rr_setup_ddata", 64'(dist_data), 64'(rr_data[exp_g[k]]));
         tick(); credit_return = 1'b1; #1;
         chk("rr_issue_dvalid", 64'(dist_valid), 64'h1);
         tick(); credit_return = 1'b0;
         exp_cnt++;
      end
      #1;
      chk("rr_cnt", 64'(issued_cnt), 64'(exp_cnt));
      chk("rr_err", 64'(err_credit), 64'h0);
      chk("rr_disabled_ready", 64'(req_ready), 64'h0);

      // Extra return at full credits
      req_valid = '0; credit_return = 1'b1; tick(); credit_return = 1'b0; #1;
      chk("err_set", 64'(err_credit), 64'h1);
      req_valid = 4'b0001; req_enable = 4'b1111; #1;
      chk("err_one_credit", 64'(req_ready), 64'h1);
      tick(); tick(); tick(); #1;
      chk("err_no_second", 64'(req_ready), 64'h0);
      tick(); #1;
      chk("err_sticky", 64'(err_credit), 64'h1);
      exp_cnt++;
      chk("final_cnt", 64'(issued_cnt), 64'(exp_cnt));
      chk("wrap_cnt", 64'(w_issued_cnt), 64'(exp_cnt % 4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
